// File: rtl/muldiv_unit_pkg.sv
// Shared execute-stage types: M-extension operation encoding and control word.
package muldiv_unit_pkg;

    // M-extension operations, encoded as the RISC-V funct3 field.
    typedef enum logic [2:0] {
        MD_MUL    = 3'b000,
        MD_MULH   = 3'b001,
        MD_MULHSU = 3'b010,
        MD_MULHU  = 3'b011,
        MD_DIV    = 3'b100,
        MD_DIVU   = 3'b101,
        MD_REM    = 3'b110,
        MD_REMU   = 3'b111
    } md_op_type;

    // funct7 value that selects the M extension within OP instructions.
    localparam logic [6:0] MD_FUNCT7 = 7'b0000001;

    // Decoded control word carried down the pipeline.
    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic is_muldiv;
    } control_type;

    // funct3[2] separates divides/remainders from multiplies.
    function automatic logic op_is_div(input md_op_type o);
        return o[2];
    endfunction

    // REM/REMU return the remainder half of the divide datapath.
    function automatic logic op_is_rem(input md_op_type o);
        return o[2] & o[1];
    endfunction

    // rs1 is read as two's complement.
    function automatic logic op_a_signed(input md_op_type o);
        return (o == MD_MULH) || (o == MD_MULHSU) || (o == MD_DIV) || (o == MD_REM);
    endfunction

    // rs2 is read as two's complement.
    function automatic logic op_b_signed(input md_op_type o);
        return (o == MD_MULH) || (o == MD_DIV) || (o == MD_REM);
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide,
// one bit per cycle on a shared accumulator pair, valid/ready on both sides.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  md_op_type       op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_type;

    state_type         state_q, state_d;
    logic [CW-1:0]     cnt_q;
    md_op_type         op_q;
    logic              neg_q;       // final result must be negated
    logic              fast_q;      // corner case: acc_hi already holds the answer
    logic [XLEN-1:0]   opnd_q;      // multiplicand or divisor magnitude
    logic [XLEN-1:0]   acc_hi;      // product high half / partial remainder
    logic [XLEN-1:0]   acc_lo;      // multiplier / dividend, shifts into quotient

    logic              last_step;
    logic              a_neg, b_neg;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic              div_zero, div_ovf, fast;
    logic [XLEN-1:0]   corner_res;
    logic [XLEN:0]     mul_sum, div_trial;
    logic [XLEN-1:0]   hi_nx, lo_nx;
    logic [2*XLEN-1:0] prod_raw, prod_fix;
    logic [XLEN-1:0]   res_formed;

    assign last_step = (cnt_q == CW'(XLEN - 1));

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments make every register sample pre-edge values, independent of block order.
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state and handshake outputs; both outputs depend on state only.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = CALC;
            end
            CALC: begin
                if (fast_q || last_step) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand magnitudes and single-cycle corner-case answers for the request.
    always_comb begin
        a_neg    = op_a_signed(op) & a[XLEN-1];
        b_neg    = op_b_signed(op) & b[XLEN-1];
        a_mag    = a_neg ? -a : a;
        b_mag    = b_neg ? -b : b;
        div_zero = (b == '0);
        div_ovf  = ((op == MD_DIV) || (op == MD_REM)) && (a == MOST_NEG) && (b == '1);
        fast     = op_is_div(op) && (div_zero || div_ovf);
        if (op_is_rem(op)) corner_res = div_zero ? a  : '0;
        else               corner_res = div_zero ? '1 : MOST_NEG;
    end

    // One iteration: shift-add multiply step or restoring divide step.
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd_q} : '0);
        div_trial = {acc_hi, acc_lo[XLEN-1]} - {1'b0, opnd_q};
        if (op_is_div(op_q)) begin
            if (!div_trial[XLEN]) begin
                hi_nx = div_trial[XLEN-1:0];
                lo_nx = {acc_lo[XLEN-2:0], 1'b1};
            end else begin
                hi_nx = {acc_hi[XLEN-2:0], acc_lo[XLEN-1]};
                lo_nx = {acc_lo[XLEN-2:0], 1'b0};
            end
        end else begin
            {hi_nx, lo_nx} = {mul_sum, acc_lo[XLEN-1:1]};
        end
    end

    // Sign fix and half selection, applied to the values of the final step.
    always_comb begin
        prod_raw = {hi_nx, lo_nx};
        prod_fix = neg_q ? -prod_raw : prod_raw;
        case (op_q)
            MD_MUL:                        res_formed = prod_fix[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU:  res_formed = prod_fix[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:               res_formed = neg_q ? -lo_nx : lo_nx;
            default:                       res_formed = neg_q ? -hi_nx : hi_nx;
        endcase
    end

    // Operand capture, iteration and result register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            op_q   <= MD_MUL;
            neg_q  <= 1'b0;
            fast_q <= 1'b0;
            opnd_q <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            result <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        op_q   <= op;
                        cnt_q  <= '0;
                        fast_q <= fast;
                        // Remainder follows the dividend; everything else follows sign(a)^sign(b).
                        neg_q  <= op_is_rem(op) ? a_neg : (a_neg ^ b_neg);
                        opnd_q <= op_is_div(op) ? b_mag : a_mag;
                        acc_hi <= fast ? corner_res : '0;
                        acc_lo <= op_is_div(op) ? a_mag : b_mag;
                    end
                end
                CALC: begin
                    if (fast_q) begin
                        result <= acc_hi;
                    end else begin
                        acc_hi <= hi_nx;
                        acc_lo <= lo_nx;
                        cnt_q  <= last_step ? '0 : cnt_q + CW'(1);
                        if (last_step) result <= res_formed;
                    end
                end
                DONE: begin
                    if (out_ready) result <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit at XLEN=32 and XLEN=16.
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    logic        clk;
    logic        reset;
    logic        in_valid, in_ready, out_valid, out_ready;
    md_op_type   op;
    logic [31:0] a, b, result;

    logic        in_valid16, in_ready16, out_valid16, out_ready16;
    md_op_type   op16;
    logic [15:0] a16, b16, result16;

    int total;
    int bad;

    muldiv_unit #(.XLEN(32)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .result(result)
    );

    muldiv_unit #(.XLEN(16)) dut16 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid16), .in_ready(in_ready16), .op(op16), .a(a16), .b(b16),
        .out_valid(out_valid16), .out_ready(out_ready16), .result(result16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Issue one request on the 32-bit unit, measure edges to out_valid, check result, then retire it.
    task automatic do_op(input string tag, input md_op_type o, input logic [31:0] av,
                         input logic [31:0] bv, input int exp_lat, input logic [31:0] exp_res);
        int n;
        op = o; a = av; b = bv; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; op = MD_MULHU; a = $urandom; b = $urandom;
        n = 0;
        while (!out_valid && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, " latency"}, n, exp_lat);
        check({tag, " result"}, result, exp_res);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, " ready after"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        int n;
        logic [31:0] held;
        total = 0; bad = 0;
        reset = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0; op = MD_MUL; a = '0; b = '0;
        in_valid16 = 1'b0; out_ready16 = 1'b0; op16 = MD_MUL; a16 = '0; b16 = '0;
        @(posedge clk); @(posedge clk); #1;
        check("reset in_ready", {31'd0, in_ready}, 32'd1);
        check("reset out_valid", {31'd0, out_valid}, 32'd0);
        check("reset result", result, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Main function.
        do_op("mul 7*-3",       MD_MUL,    32'd7,        32'hFFFFFFFD, 32, 32'hFFFFFFEB);
        do_op("mulh -1*-1",     MD_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32, 32'h00000000);
        do_op("mulhsu -1*max",  MD_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32, 32'hFFFFFFFF);
        do_op("mulhu max*max",  MD_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32, 32'hFFFFFFFE);
        do_op("mulh min*min",   MD_MULH,   32'h80000000, 32'h80000000, 32, 32'h40000000);
        do_op("div -7/2",       MD_DIV,    32'hFFFFFFF9, 32'd2,        32, 32'hFFFFFFFD);
        do_op("rem -7/2",       MD_REM,    32'hFFFFFFF9, 32'd2,        32, 32'hFFFFFFFF);
        do_op("divu 100/7",     MD_DIVU,   32'd100,      32'd7,        32, 32'd14);
        do_op("remu 100/7",     MD_REMU,   32'd100,      32'd7,        32, 32'd2);

        // Corner cases resolve one edge after accept.
        do_op("div 5/0",        MD_DIV,    32'd5,        32'd0,        1,  32'hFFFFFFFF);
        do_op("remu 5/0",       MD_REMU,   32'd5,        32'd0,        1,  32'd5);
        do_op("div ovf",        MD_DIV,    32'h80000000, 32'hFFFFFFFF, 1,  32'h80000000);
        do_op("rem ovf",        MD_REM,    32'h80000000, 32'hFFFFFFFF, 1,  32'd0);

        // Backpressure: hold out_ready low while a competing request is presented.
        op = MD_DIVU; a = 32'd100; b = 32'd7; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("bp latency", n, 32);
        held = result;
        check("bp first result", held, 32'd14);
        op = MD_MUL; a = 32'd3; b = 32'd3; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("bp result held", result, 32'd14);
            check("bp in_ready low", {31'd0, in_ready}, 32'd0);
            check("bp out_valid held", {31'd0, out_valid}, 32'd1);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp in_ready after", {31'd0, in_ready}, 32'd1);
        check("bp out_valid after", {31'd0, out_valid}, 32'd0);
        check("bp result cleared", result, 32'd0);
        @(posedge clk); #1;
        check("bp no stray accept", {31'd0, in_ready}, 32'd1);

        // Reset in the middle of CALC, with in_valid held through the reset edge.
        op = MD_MUL; a = 32'd1234; b = 32'd5678; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("mid-op busy", {31'd0, in_ready}, 32'd0);
        reset = 1'b1; in_valid = 1'b1; op = MD_MULHU; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF;
        @(posedge clk); #1;
        reset = 1'b0; in_valid = 1'b0;
        check("rst in_ready", {31'd0, in_ready}, 32'd1);
        check("rst out_valid", {31'd0, out_valid}, 32'd0);
        check("rst result", result, 32'd0);
        do_op("mulhu 3*5 after rst", MD_MULHU, 32'd3, 32'd5, 32, 32'd0);

        // Narrow instance: same multiply at XLEN=16.
        op16 = MD_MUL; a16 = 16'd7; b16 = 16'hFFFD; in_valid16 = 1'b1;
        @(posedge clk); #1;
        in_valid16 = 1'b0; a16 = 16'hA5A5; b16 = 16'h5A5A;
        n = 0;
        while (!out_valid16 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("x16 mul latency", n, 16);
        check("x16 mul result", {16'd0, result16}, 32'h0000FFEB);
        out_ready16 = 1'b1;
        @(posedge clk); #1;
        out_ready16 = 1'b0;
        check("x16 ready after", {31'd0, in_ready16}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
